// File: rtl/gpio_sched_pkg.sv
// gpio_sched_pkg: shared offsets, CTRL bit indices and FSM states
// for the GPIO pattern scheduler.
package gpio_sched_pkg;

    localparam logic [31:0] GPIO_DIR   = 32'h00;
    localparam logic [31:0] GPIO_A     = 32'h04;
    localparam logic [31:0] GPIO_B     = 32'h08;
    localparam logic [31:0] SCHED_CTRL = 32'h10;
    localparam logic [31:0] SCHED_LEN  = 32'h14;
    localparam logic [31:0] SCHED_PER  = 32'h18;
    localparam logic [31:0] SCHED_TBL  = 32'h1C;
    localparam logic [31:0] SCHED_STAT = 32'h20;

    localparam int CTRL_GO   = 0;
    localparam int CTRL_LOOP = 1;
    localparam int CTRL_BLK  = 2;
    localparam int TBL_CLR   = 31;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        PEND
    } state_e;

endpackage

// File: rtl/mod_gpio_sched_if.sv
// mod_gpio_sched_if: CPU-side data bus plus downstream mod_gpio port.
// slave = scheduler view, master = CPU/GPIO environment view.
interface mod_gpio_sched_if;

    logic        cpu_de;
    logic [1:0]  cpu_drw;
    logic [31:0] cpu_daddr;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        cpu_stall;
    logic        gpio_de;
    logic [1:0]  gpio_drw;
    logic [31:0] gpio_daddr;
    logic [31:0] gpio_din;
    logic [31:0] gpio_dout;

    modport slave (
        input  cpu_de, cpu_drw, cpu_daddr, cpu_din, gpio_dout,
        output cpu_dout, cpu_stall,
        output gpio_de, gpio_drw, gpio_daddr, gpio_din
    );

    modport master (
        output cpu_de, cpu_drw, cpu_daddr, cpu_din, gpio_dout,
        input  cpu_dout, cpu_stall,
        input  gpio_de, gpio_drw, gpio_daddr, gpio_din
    );

endinterface

// File: rtl/gpio_sched_tbl.sv
// gpio_sched_tbl: DEPTH x 8 pattern table, auto-incrementing write
// pointer with clear, one asynchronous read port.
module gpio_sched_tbl #(
    parameter int DEPTH = 16,
    parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          clr_i,
    input  logic [7:0]    wdata_i,
    input  logic [IW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [IW-1:0] wptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
        end else if (we_i) begin
            mem_q[wptr_q] <= wdata_i;
            wptr_q        <= wptr_q + 1'b1;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mod_gpio_sched.sv
// mod_gpio_sched: CPU pass-through plus table step sequencer, both
// arbitrated onto one mod_gpio port. Optional IRQ: GPIO_SCHED_IRQ_EN.
module mod_gpio_sched
    import gpio_sched_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PER_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    mod_gpio_sched_if.slave   bus,
    output logic              seq_irq
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = IW + 1;

    logic [31:0]    a;
    logic           wr, rd, fwd;
    logic           wr_ctrl, wr_len, wr_per, wr_tbl;
    logic           start, stop;
    logic [2:0]     ctrl_q;
    logic [LW-1:0]  len_q, len_wr, len_eff;
    logic [PER_W-1:0] per_q, per_wr, per_eff;
    state_e         state_q, state_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [LW-1:0]  nxt;
    logic           last, pend, seq_win;
    logic           lost_q, lost_d;
    logic [7:0]     tbl_rd;
    logic           done_bit;
    logic [31:0]    status;

    assign a       = bus.cpu_daddr;
    assign wr      = bus.cpu_de & bus.cpu_drw[0];
    assign rd      = bus.cpu_de & ~bus.cpu_drw[0];
    assign fwd     = bus.cpu_de &
                     (a == GPIO_DIR || a == GPIO_A || a == GPIO_B);
    assign wr_ctrl = wr && a == SCHED_CTRL;
    assign wr_len  = wr && a == SCHED_LEN;
    assign wr_per  = wr && a == SCHED_PER;
    assign wr_tbl  = wr && a == SCHED_TBL;
    assign start   = wr_ctrl && bus.cpu_din[CTRL_GO] && state_q == IDLE;
    assign stop    = wr_ctrl && !bus.cpu_din[CTRL_GO];

    always_comb begin
        len_wr = bus.cpu_din[LW-1:0];
        if (bus.cpu_din == 32'd0)
            len_wr = LW'(1);
        else if (bus.cpu_din > 32'(DEPTH))
            len_wr = LW'(DEPTH);
    end

    assign per_wr  = (bus.cpu_din[PER_W-1:0] == '0) ?
                     PER_W'(1) : bus.cpu_din[PER_W-1:0];
    assign len_eff = (len_q == '0) ? LW'(1) : len_q;
    assign per_eff = (per_q == '0) ? PER_W'(1) : per_q;

    gpio_sched_tbl #(.DEPTH(DEPTH), .IW(IW)) u_tbl (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_tbl & ~bus.cpu_din[TBL_CLR]),
        .clr_i   (wr_tbl & bus.cpu_din[TBL_CLR]),
        .wdata_i (bus.cpu_din[7:0]),
        .raddr_i (idx_q),
        .rdata_o (tbl_rd)
    );

    // A go=0 write cancels a pending step in the same cycle
    assign nxt     = {1'b0, idx_q} + LW'(1);
    assign last    = nxt == len_eff;
    assign pend    = state_q == PEND && !stop;
    assign seq_win = pend && (!fwd || lost_q);

    always_comb begin
        lost_d = lost_q;
        if (stop || seq_win) lost_d = 1'b0;
        else if (pend && fwd) lost_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (start) state_d = LOAD;
                LOAD: begin
                    cnt_d   = per_eff;
                    idx_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (cnt_q <= PER_W'(1)) state_d = PEND;
                    else cnt_d = cnt_q - 1'b1;
                end
                PEND: begin
                    if (seq_win) begin
                        idx_d = nxt[IW-1:0];
                        if (last && !ctrl_q[CTRL_LOOP]) begin
                            state_d = IDLE;
                        end else begin
                            if (last) idx_d = '0;
                            // Next step keeps exactly PERIOD-cycle spacing
                            state_d = (per_eff == PER_W'(1)) ? PEND : WAIT;
                            cnt_d   = per_eff - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= '0;
            len_q   <= '0;
            per_q   <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_q <= bus.cpu_din[2:0];
            if (wr_len)  len_q  <= len_wr;
            if (wr_per)  per_q  <= per_wr;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lost_q  <= lost_d;
        end
    end

`ifdef GPIO_SCHED_IRQ_EN
    logic irq_q, done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            irq_q <= seq_win && last;
            if (seq_win && last) done_q <= 1'b1;
            else if (rd && a == SCHED_STAT) done_q <= 1'b0;
        end
    end

    assign seq_irq  = irq_q;
    assign done_bit = done_q;
`else
    assign seq_irq  = 1'b0;
    assign done_bit = 1'b0;
`endif

    assign status = {16'h0, 8'(idx_q), 5'h0, done_bit,
                     state_q == PEND, state_q != IDLE};

    always_comb begin
        bus.gpio_de    = 1'b0;
        bus.gpio_drw   = 2'b00;
        bus.gpio_daddr = '0;
        bus.gpio_din   = '0;
        bus.cpu_stall  = fwd && seq_win;
        bus.cpu_dout   = '0;
        if (seq_win) begin
            bus.gpio_de    = 1'b1;
            bus.gpio_drw   = 2'b01;
            bus.gpio_daddr = ctrl_q[CTRL_BLK] ? GPIO_B : GPIO_A;
            bus.gpio_din   = {24'h0, tbl_rd};
        end else if (fwd) begin
            bus.gpio_de    = 1'b1;
            bus.gpio_drw   = bus.cpu_drw;
            bus.gpio_daddr = a;
            bus.gpio_din   = bus.cpu_din;
        end
        if (fwd) begin
            bus.cpu_dout = bus.gpio_dout;
        end else if (rd) begin
            case (a)
                SCHED_CTRL: bus.cpu_dout = {29'h0, ctrl_q};
                SCHED_LEN:  bus.cpu_dout = 32'(len_q);
                SCHED_PER:  bus.cpu_dout = 32'(per_q);
                SCHED_STAT: bus.cpu_dout = status;
                default:    bus.cpu_dout = '0;
            endcase
        end
    end

endmodule
